// File: rtl/dmem_pkg.sv
// Shared encodings, MMIO offsets, FSM states and lane helpers for the data memory controller.
package dmem_pkg;

  typedef enum logic [1:0] {
    SIZE_BYTE = 2'd0,
    SIZE_HALF = 2'd1,
    SIZE_WORD = 2'd2,
    SIZE_BAD  = 2'd3
  } size_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam logic [31:0] MMIO_CNT_OFS  = 32'h0000_0000;
  localparam logic [31:0] MMIO_GPIO_OFS = 32'h0000_0004;

  function automatic logic [3:0] lane_enables(input size_e size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      SIZE_BYTE: be = 4'b0001 << lane;
      SIZE_HALF: be = lane[1] ? 4'b1100 : 4'b0011;
      SIZE_WORD: be = 4'b1111;
      default:   be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate right-aligned store data so every enabled lane sees the right bytes.
  function automatic logic [31:0] store_align(input size_e size, input logic [31:0] wdata);
    logic [31:0] w;
    case (size)
      SIZE_BYTE: w = {4{wdata[7:0]}};
      SIZE_HALF: w = {2{wdata[15:0]}};
      default:   w = wdata;
    endcase
    return w;
  endfunction

  function automatic logic [31:0] load_extend(input size_e size, input logic [1:0] lane,
                                              input logic uns, input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = lane[1] ? word[31:16] : word[15:0];
    case (size)
      SIZE_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
      SIZE_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_byte_ram.sv
// Word-organised RAM with per-byte write enables and an asynchronous read port.
module dmem_byte_ram
  import dmem_pkg::*;
#(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       rdata
);

  logic [31:0] mem_q [DEPTH];

  // Contents are deliberately left out of reset.
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (we[b]) begin
        mem_q[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  assign rdata = mem_q[addr];

endmodule

// File: rtl/data_mem_ctrl.sv
// Load/store data memory controller: byte-lane RAM, MMIO cycle counter and GPIO, fixed load latency.
module data_mem_ctrl
  import dmem_pkg::*;
#(
  parameter int          MP_DATA_WIDTH = 32,
  parameter int          MP_DEPTH      = 256,
  parameter int          MP_RD_LATENCY = 1,
  parameter logic [31:0] MP_MMIO_BASE  = 32'hFFFF_0000
) (
  input  logic                     iclk,
  input  logic                     irst,
  input  logic                     ireq,
  input  logic                     iwen,
  input  logic [1:0]               isize,
  input  logic                     iunsigned,
  input  logic [MP_DATA_WIDTH-1:0] iaddr,
  input  logic [MP_DATA_WIDTH-1:0] iwdata,
  output logic                     obusy,
  output logic                     ovalid,
  output logic [MP_DATA_WIDTH-1:0] ordata,
  output logic                     ofault,
  output logic [MP_DATA_WIDTH-1:0] ogpio
);

  localparam int          IDX_W     = $clog2(MP_DEPTH);
  localparam logic [31:0] RAM_BYTES = 32'(MP_DEPTH * 4);
  localparam logic [31:0] CNT_ADDR  = MP_MMIO_BASE + MMIO_CNT_OFS;
  localparam logic [31:0] GPIO_ADDR = MP_MMIO_BASE + MMIO_GPIO_OFS;
  localparam logic [1:0]  LAT_INIT  = (MP_RD_LATENCY > 1) ? 2'(MP_RD_LATENCY - 2) : 2'd0;

  state_e      state_q, state_d;
  logic [1:0]  lat_cnt_q, lat_cnt_d;
  logic [31:0] pend_data_q, pend_data_d;
  logic        pend_fault_q, pend_fault_d;
  logic        valid_q, valid_d;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;
  logic [31:0] gpio_q, gpio_d;
  logic [31:0] cycle_q, cycle_d;

  size_e            size;
  logic [1:0]       lane;
  logic [IDX_W-1:0] ram_idx;
  logic             align_ok;
  logic             in_ram;
  logic             is_cnt;
  logic             is_gpio;
  logic             acc_fault;
  logic             accept;
  logic             need_resp;
  logic [31:0]      ram_rdata;
  logic [31:0]      load_word;
  logic [31:0]      resp_data;
  logic [3:0]       ram_we;

  assign size    = size_e'(isize);
  assign lane    = iaddr[1:0];
  assign ram_idx = iaddr[IDX_W+1:2];
  assign obusy   = (state_q == ST_WAIT);

  // Address decode and fault classification for the request on the inputs this cycle.
  always_comb begin
    align_ok = 1'b0;
    case (size)
      SIZE_BYTE: align_ok = 1'b1;
      SIZE_HALF: align_ok = ~iaddr[0];
      SIZE_WORD: align_ok = (iaddr[1:0] == 2'b00);
      default:   align_ok = 1'b0;
    endcase
    in_ram    = (iaddr < RAM_BYTES);
    is_cnt    = (iaddr == CNT_ADDR);
    is_gpio   = (iaddr == GPIO_ADDR);
    acc_fault = ~align_ok | ~(in_ram | ((is_cnt | is_gpio) & (size == SIZE_WORD)));
    accept    = ireq & ~obusy;
    need_resp = accept & (~iwen | acc_fault);
    load_word = in_ram ? ram_rdata : (is_cnt ? cycle_q : gpio_q);
    resp_data = acc_fault ? 32'h0 : load_extend(size, lane, iunsigned, load_word);
    ram_we    = (accept & iwen & ~acc_fault & in_ram) ? lane_enables(size, lane) : 4'b0000;
  end

  dmem_byte_ram #(
    .DEPTH  (MP_DEPTH),
    .ADDR_W (IDX_W)
  ) u_ram (
    .clk   (iclk),
    .we    (ram_we),
    .addr  (ram_idx),
    .wdata (store_align(size, iwdata)),
    .rdata (ram_rdata)
  );

  // Response data is snapshotted at acceptance and released when the latency counter expires.
  always_comb begin
    state_d      = state_q;
    lat_cnt_d    = lat_cnt_q;
    pend_data_d  = pend_data_q;
    pend_fault_d = pend_fault_q;
    valid_d      = 1'b0;
    rdata_d      = rdata_q;
    fault_d      = fault_q;
    gpio_d       = gpio_q;
    cycle_d      = cycle_q + 32'd1;

    if (accept && iwen && !acc_fault && is_gpio) begin
      gpio_d = iwdata;
    end

    case (state_q)
      ST_IDLE: begin
        if (need_resp) begin
          if (MP_RD_LATENCY == 1) begin
            valid_d = 1'b1;
            rdata_d = resp_data;
            fault_d = acc_fault;
          end else begin
            state_d      = ST_WAIT;
            lat_cnt_d    = LAT_INIT;
            pend_data_d  = resp_data;
            pend_fault_d = acc_fault;
          end
        end
      end
      ST_WAIT: begin
        if (lat_cnt_q == 2'd0) begin
          state_d = ST_IDLE;
          valid_d = 1'b1;
          rdata_d = pend_data_q;
          fault_d = pend_fault_q;
        end else begin
          lat_cnt_d = lat_cnt_q - 2'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q      <= ST_IDLE;
      lat_cnt_q    <= 2'd0;
      pend_data_q  <= 32'h0;
      pend_fault_q <= 1'b0;
      valid_q      <= 1'b0;
      rdata_q      <= 32'h0;
      fault_q      <= 1'b0;
      gpio_q       <= 32'h0;
      cycle_q      <= 32'h0;
    end else begin
      state_q      <= state_d;
      lat_cnt_q    <= lat_cnt_d;
      pend_data_q  <= pend_data_d;
      pend_fault_q <= pend_fault_d;
      valid_q      <= valid_d;
      rdata_q      <= rdata_d;
      fault_q      <= fault_d;
      gpio_q       <= gpio_d;
      cycle_q      <= cycle_d;
    end
  end

  assign ovalid = valid_q;
  assign ordata = rdata_q;
  assign ofault = fault_q;
  assign ogpio  = gpio_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench: main instance at read latency 3, a second instance at latency 1 for the zero-busy path.
module tb_data_mem_ctrl;
  import dmem_pkg::*;

  localparam int          LAT  = 3;
  localparam logic [31:0] BASE = 32'hFFFF_0000;

  logic        clk  = 1'b0;
  logic        irst = 1'b1;
  logic        ireq = 1'b0, iwen = 1'b0, iunsigned = 1'b0;
  logic [1:0]  isize = 2'd0;
  logic [31:0] iaddr = 32'h0, iwdata = 32'h0;
  logic        obusy, ovalid, ofault;
  logic [31:0] ordata, ogpio;

  logic        req1 = 1'b0, wen1 = 1'b0, uns1 = 1'b0;
  logic [1:0]  size1 = 2'd0;
  logic [31:0] addr1 = 32'h0, wdata1 = 32'h0;
  logic        busy1, valid1, fault1;
  logic [31:0] rdata1, gpio1;

  int errors = 0;
  int checks = 0;
  int tb_cyc = 0;
  int ovalid_seen = 0;
  logic [31:0] last_resp = 32'h0;
  logic [31:0] hold_data = 32'h0;
  logic        hold_fault = 1'b0;

  typedef struct {
    logic [31:0] data;
    logic        fault;
    logic        chk;
    int          due;
  } exp_t;
  exp_t exp_q[$];

  logic [7:0] mb [16];

  data_mem_ctrl #(.MP_DATA_WIDTH(32), .MP_DEPTH(256), .MP_RD_LATENCY(LAT), .MP_MMIO_BASE(BASE)) dut (
    .iclk(clk), .irst(irst), .ireq(ireq), .iwen(iwen), .isize(isize), .iunsigned(iunsigned),
    .iaddr(iaddr), .iwdata(iwdata), .obusy(obusy), .ovalid(ovalid), .ordata(ordata),
    .ofault(ofault), .ogpio(ogpio)
  );

  data_mem_ctrl #(.MP_DATA_WIDTH(32), .MP_DEPTH(256), .MP_RD_LATENCY(1), .MP_MMIO_BASE(BASE)) dut1 (
    .iclk(clk), .irst(irst), .ireq(req1), .iwen(wen1), .isize(size1), .iunsigned(uns1),
    .iaddr(addr1), .iwdata(wdata1), .obusy(busy1), .ovalid(valid1), .ordata(rdata1),
    .ofault(fault1), .ogpio(gpio1)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) tb_cyc <= tb_cyc + 1;

  // Pops the scoreboard on every response and checks output hold between responses.
  always @(negedge clk) begin : monitor
    exp_t e;
    if (irst) begin
      hold_data  = 32'h0;
      hold_fault = 1'b0;
    end else if (ovalid) begin
      ovalid_seen++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("[TB] FAIL unexpected_ovalid: got ordata=%h ofault=%b, required no response", ordata, ofault);
      end else begin
        e = exp_q.pop_front();
        checks++;
        if (tb_cyc != e.due) begin
          errors++;
          $display("[TB] FAIL resp_timing: got cycle %0d, required %0d", tb_cyc, e.due);
        end
        checks++;
        if (ofault !== e.fault) begin
          errors++;
          $display("[TB] FAIL resp_fault: got %b, required %b", ofault, e.fault);
        end
        if (e.chk) begin
          checks++;
          if (ordata !== e.data) begin
            errors++;
            $display("[TB] FAIL resp_data: got %h, required %h", ordata, e.data);
          end
        end
      end
      last_resp  = ordata;
      hold_data  = ordata;
      hold_fault = ofault;
    end else begin
      checks++;
      if (ordata !== hold_data || ofault !== hold_fault) begin
        errors++;
        $display("[TB] FAIL hold: got ordata=%h ofault=%b, required %h %b", ordata, ofault, hold_data, hold_fault);
      end
    end
  end

  task automatic issue(input logic wen, input logic [1:0] size, input logic uns,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic resp, input logic [31:0] exp_data, input logic exp_fault,
                       input logic chk);
    @(negedge clk);
    ireq = 1'b1; iwen = wen; isize = size; iunsigned = uns; iaddr = addr; iwdata = wdata;
    if (resp) exp_q.push_back('{data: exp_data, fault: exp_fault, chk: chk, due: tb_cyc + LAT});
    @(negedge clk);
    ireq = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain_timeout: got %0d pending responses, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks += 8;
    if (obusy  !== 1'b0)  begin errors++; $display("[TB] FAIL reset_obusy: got %b, required 0", obusy); end
    if (ovalid !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ovalid: got %b, required 0", ovalid); end
    if (ordata !== 32'h0) begin errors++; $display("[TB] FAIL reset_ordata: got %h, required 0", ordata); end
    if (ofault !== 1'b0)  begin errors++; $display("[TB] FAIL reset_ofault: got %b, required 0", ofault); end
    if (ogpio  !== 32'h0) begin errors++; $display("[TB] FAIL reset_ogpio: got %h, required 0", ogpio); end
    if (busy1  !== 1'b0)  begin errors++; $display("[TB] FAIL reset_busy1: got %b, required 0", busy1); end
    if (valid1 !== 1'b0)  begin errors++; $display("[TB] FAIL reset_valid1: got %b, required 0", valid1); end
    if (gpio1  !== 32'h0) begin errors++; $display("[TB] FAIL reset_gpio1: got %h, required 0", gpio1); end
    irst = 1'b0;
    // First post-reset edge counts to 1, so the read accepted on the following edge returns 1.
    issue(1'b0, SIZE_WORD, 1'b0, BASE, 32'h0, 1'b1, 32'd1, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_store_load();
    issue(1'b1, SIZE_WORD, 1'b0, 32'h10, 32'h8899_AABB, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (obusy !== 1'b0) begin errors++; $display("[TB] FAIL store_obusy: got %b, required 0", obusy); end
    issue(1'b0, SIZE_BYTE, 1'b0, 32'h11, 32'h0, 1'b1, 32'hFFFF_FFAA, 1'b0, 1'b1);
    wait_drain();
    issue(1'b1, SIZE_HALF, 1'b0, 32'h12, 32'h0000_1234, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_AABB, 1'b0, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_HALF, 1'b1, 32'h12, 32'h0, 1'b1, 32'h0000_1234, 1'b0, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_HALF, 1'b0, 32'h10, 32'h0, 1'b1, 32'hFFFF_AABB, 1'b0, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h13, 32'h0, 1'b1, 32'h0000_0012, 1'b0, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_BYTE, 1'b0, 32'h12, 32'h0, 1'b1, 32'h0000_0034, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_latency();
    int seen0;
    seen0 = ovalid_seen;
    @(negedge clk);
    ireq = 1'b1; iwen = 1'b0; isize = SIZE_WORD; iunsigned = 1'b0; iaddr = 32'h10;
    exp_q.push_back('{data: 32'h1234_AABB, fault: 1'b0, chk: 1'b1, due: tb_cyc + LAT});
    @(negedge clk);
    checks += 2;
    if (obusy !== 1'b1)  begin errors++; $display("[TB] FAIL lat_busy_c1: got %b, required 1", obusy); end
    if (ovalid !== 1'b0) begin errors++; $display("[TB] FAIL lat_valid_c1: got %b, required 0", ovalid); end
    iaddr = 32'h14;
    @(negedge clk);
    checks++;
    if (obusy !== 1'b1) begin errors++; $display("[TB] FAIL lat_busy_c2: got %b, required 1", obusy); end
    ireq = 1'b0;
    @(negedge clk);
    checks += 2;
    if (obusy !== 1'b0)  begin errors++; $display("[TB] FAIL lat_busy_c3: got %b, required 0", obusy); end
    if (ovalid !== 1'b1) begin errors++; $display("[TB] FAIL lat_valid_c3: got %b, required 1", ovalid); end
    ireq = 1'b1; isize = SIZE_HALF; iunsigned = 1'b1; iaddr = 32'h12;
    exp_q.push_back('{data: 32'h0000_1234, fault: 1'b0, chk: 1'b1, due: tb_cyc + LAT});
    @(negedge clk);
    ireq = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);
    checks++;
    if (ovalid_seen - seen0 != 2) begin
      errors++;
      $display("[TB] FAIL lat_drop_count: got %0d responses, required 2", ovalid_seen - seen0);
    end
  endtask

  task automatic test_faults();
    issue(1'b0, SIZE_HALF, 1'b0, 32'h03, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_WORD, 1'b0, 32'h400, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_BAD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    issue(1'b1, SIZE_WORD, 1'b0, 32'h11, 32'hFFFF_FFFF, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h800, 32'h55, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_WORD, 1'b0, 32'h10, 32'h0, 1'b1, 32'h1234_AABB, 1'b0, 1'b1);
    wait_drain();
    issue(1'b1, SIZE_BYTE, 1'b0, 32'h3FF, 32'h7E, 1'b0, 32'h0, 1'b0, 1'b0);
    issue(1'b0, SIZE_BYTE, 1'b1, 32'h3FF, 32'h0, 1'b1, 32'h0000_007E, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_mmio();
    int seen0;
    issue(1'b1, SIZE_WORD, 1'b0, BASE + 32'h4, 32'hDEAD_BEEF, 1'b0, 32'h0, 1'b0, 1'b0);
    checks++;
    if (ogpio !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL gpio_write: got %h, required deadbeef", ogpio); end
    issue(1'b0, SIZE_WORD, 1'b0, BASE + 32'h4, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b0, 1'b1);
    wait_drain();
    issue(1'b1, SIZE_BYTE, 1'b0, BASE + 32'h4, 32'h11, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    checks++;
    if (ogpio !== 32'hDEAD_BEEF) begin errors++; $display("[TB] FAIL gpio_byte_keep: got %h, required deadbeef", ogpio); end
    issue(1'b1, SIZE_HALF, 1'b0, BASE, 32'h11, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    issue(1'b0, SIZE_WORD, 1'b0, BASE + 32'h8, 32'h0, 1'b1, 32'h0, 1'b1, 1'b1);
    wait_drain();
    seen0 = ovalid_seen;
    issue(1'b1, SIZE_WORD, 1'b0, BASE, 32'h1234_5678, 1'b0, 32'h0, 1'b0, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if (ovalid_seen != seen0) begin errors++; $display("[TB] FAIL cnt_store_silent: got %0d responses, required 0", ovalid_seen - seen0); end
  endtask

  task automatic test_counter();
    logic [31:0] cnt_a;
    issue(1'b0, SIZE_WORD, 1'b0, BASE, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    cnt_a = last_resp;
    issue(1'b0, SIZE_WORD, 1'b0, BASE, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_drain();
    checks++;
    if (last_resp - cnt_a !== 32'd5) begin
      errors++;
      $display("[TB] FAIL counter_delta: got %0d, required 5", last_resp - cnt_a);
    end
  endtask

  task automatic test_back_to_back();
    @(negedge clk);
    ireq = 1'b1; iwen = 1'b1; isize = SIZE_WORD; iunsigned = 1'b0; iaddr = 32'h20; iwdata = 32'hCAFE_F00D;
    @(negedge clk);
    iwen = 1'b0;
    exp_q.push_back('{data: 32'hCAFE_F00D, fault: 1'b0, chk: 1'b1, due: tb_cyc + LAT});
    @(negedge clk);
    ireq = 1'b0;
    wait_drain();
    for (int i = 0; i < 4; i++) begin
      logic [31:0] w;
      w = $urandom;
      issue(1'b1, SIZE_WORD, 1'b0, 32'h40 + 32'(4 * i), w, 1'b0, 32'h0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) mb[4*i + k] = w[8*k +: 8];
    end
    for (int i = 0; i < 8; i++) begin
      int a;
      logic [7:0] d;
      a = $urandom_range(0, 15);
      d = 8'($urandom);
      issue(1'b1, SIZE_BYTE, 1'b0, 32'h40 + 32'(a), {24'h0, d}, 1'b0, 32'h0, 1'b0, 1'b0);
      mb[a] = d;
    end
    for (int i = 0; i < 4; i++) begin
      issue(1'b0, SIZE_WORD, 1'b0, 32'h40 + 32'(4 * i), 32'h0, 1'b1,
            {mb[4*i+3], mb[4*i+2], mb[4*i+1], mb[4*i]}, 1'b0, 1'b1);
      wait_drain();
    end
    issue(1'b0, SIZE_HALF, 1'b0, 32'h46, 32'h0, 1'b1, {{16{mb[7][7]}}, mb[7], mb[6]}, 1'b0, 1'b1);
    wait_drain();
  endtask

  task automatic test_latency1();
    @(negedge clk);
    req1 = 1'b1; wen1 = 1'b1; size1 = SIZE_WORD; uns1 = 1'b0; addr1 = 32'h30; wdata1 = 32'hA5A5_5A5A;
    @(negedge clk);
    checks += 2;
    if (valid1 !== 1'b0) begin errors++; $display("[TB] FAIL l1_store_valid: got %b, required 0", valid1); end
    if (busy1 !== 1'b0)  begin errors++; $display("[TB] FAIL l1_store_busy: got %b, required 0", busy1); end
    wen1 = 1'b0;
    @(negedge clk);
    checks += 4;
    if (valid1 !== 1'b1)        begin errors++; $display("[TB] FAIL l1_valid: got %b, required 1", valid1); end
    if (rdata1 !== 32'hA5A5_5A5A) begin errors++; $display("[TB] FAIL l1_data: got %h, required a5a55a5a", rdata1); end
    if (fault1 !== 1'b0)        begin errors++; $display("[TB] FAIL l1_fault: got %b, required 0", fault1); end
    if (busy1 !== 1'b0)         begin errors++; $display("[TB] FAIL l1_busy: got %b, required 0", busy1); end
    size1 = SIZE_BYTE; uns1 = 1'b1; addr1 = 32'h31;
    @(negedge clk);
    checks += 2;
    if (valid1 !== 1'b1)      begin errors++; $display("[TB] FAIL l1_b2b_valid: got %b, required 1", valid1); end
    if (rdata1 !== 32'h5A)    begin errors++; $display("[TB] FAIL l1_b2b_data: got %h, required 0000005a", rdata1); end
    req1 = 1'b0;
    @(negedge clk);
    checks += 2;
    if (valid1 !== 1'b0)   begin errors++; $display("[TB] FAIL l1_pulse: got %b, required 0", valid1); end
    if (rdata1 !== 32'h5A) begin errors++; $display("[TB] FAIL l1_hold: got %h, required 0000005a", rdata1); end
  endtask

  task automatic test_reset_wait();
    int seen0;
    @(negedge clk);
    ireq = 1'b1; iwen = 1'b0; isize = SIZE_WORD; iunsigned = 1'b0; iaddr = 32'h10;
    @(negedge clk);
    ireq = 1'b0;
    irst = 1'b1;
    seen0 = ovalid_seen;
    @(negedge clk);
    irst = 1'b0;
    repeat (6) @(negedge clk);
    checks += 2;
    if (ovalid_seen != seen0) begin errors++; $display("[TB] FAIL rst_wait_resp: got %0d responses, required 0", ovalid_seen - seen0); end
    if (obusy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_wait_busy: got %b, required 0", obusy); end
    issue(1'b0, SIZE_WORD, 1'b0, BASE, 32'h0, 1'b1, 32'h0, 1'b0, 1'b0);
    wait_drain();
    checks++;
    if (last_resp > 32'd12) begin errors++; $display("[TB] FAIL rst_counter: got %0d, required at most 12", last_resp); end
  endtask

  initial begin
    test_reset();
    test_store_load();
    test_latency();
    test_faults();
    test_mmio();
    test_counter();
    test_back_to_back();
    test_latency1();
    test_reset_wait();
    repeat (4) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    $display("[TB] FAIL watchdog: got time limit expiry, required completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/data_mem_ctrl.md
DATA_MEM_CTRL -- requirements
Module: data_mem_ctrl

Interface
REQ-001 The block SHALL have one clock, iclk; reset irst SHALL be synchronous and active-high.
REQ-002 Parameter MP_DATA_WIDTH, default 32: data and address width.
REQ-003 Parameter MP_DEPTH, default 256: storage depth in words.
REQ-004 Parameter MP_RD_LATENCY, default 1, legal 1..4: accept-to-response cycles for loads.
REQ-005 Parameter MP_MMIO_BASE, default 32'hFFFF_0000: MMIO window base.
REQ-006 Ports SHALL be, in order:
- iclk  in  1  clock
- irst  in  1  sync active-high reset
- ireq  in  1  request strobe
- iwen  in  1  1=store, 0=load
- isize  in  2  0=byte, 1=half, 2=word, 3=illegal
- iunsigned  in  1  load zero-extend when 1, sign-extend when 0
- iaddr  in  32  byte address
- iwdata  in  32  store data, right-aligned
- obusy  out  1  load in flight; requests ignored
- ovalid  out  1  one-cycle response pulse
- ordata  out  32  extended load data
- ofault  out  1  qualifies ovalid: access faulted
- ogpio  out  32  MMIO output register

Function
REQ-007 A request SHALL be accepted on a rising edge with ireq=1 and obusy=0; requests while obusy=1 SHALL be dropped, not queued.
REQ-008 Alignment: half requires iaddr[0]=0; word requires iaddr[1:0]=0; misalignment or isize=3 SHALL fault.
REQ-009 RAM region: iaddr < MP_DEPTH*4, word index iaddr[log2(MP_DEPTH)+1:2]; any other address outside the MMIO window SHALL fault.
REQ-010 Stores SHALL commit at the accepting edge, using byte lanes: byte -> lane iaddr[1:0]; half -> lanes {iaddr[1],0}+{0,1}; word -> all lanes. Unwritten lanes SHALL be preserved.
REQ-011 A non-faulting store SHALL produce no ovalid and never raise obusy.
REQ-012 A load or faulting access SHALL raise ovalid for exactly one cycle, MP_RD_LATENCY cycles after the accepting edge.
REQ-013 obusy SHALL be high for the MP_RD_LATENCY-1 cycles between acceptance and ovalid; with latency 1 it SHALL stay low; a request on the ovalid cycle SHALL be accepted.
REQ-014 Load data: selected byte/half SHALL be taken from the addressed lane and extended per iunsigned; a word SHALL pass unchanged.
REQ-015 On fault: no state change, ordata=0, ofault=1 with ovalid; ofault SHALL be 0 with every non-fault ovalid.
REQ-016 ordata/ofault SHALL hold their values between ovalid pulses.
REQ-017 A load accepted one cycle after a store to the same word SHALL return the stored data.
REQ-018 MMIO base+0: free-running 32-bit cycle counter, +1 every cycle, wraps 32'hFFFF_FFFF -> 0; read-only, stores ignored without fault.
REQ-019 MMIO base+4: ogpio register, word read/write; byte/half MMIO accesses and unmapped MMIO offsets SHALL fault.
REQ-020 Control FSM states IDLE and WAIT: IDLE->WAIT on accepted load/fault when MP_RD_LATENCY>1; WAIT->IDLE when the latency counter expires (same cycle ovalid asserts).

Reset
REQ-021 On irst: FSM=IDLE, latency counter=0, obusy=0, ovalid=0, ordata=0, ofault=0, ogpio=0, cycle counter=0.
REQ-022 Reset during WAIT SHALL discard the pending response; no ovalid afterwards.
REQ-023 RAM contents SHALL not be reset.

Structure
REQ-024 Package dmem_pkg SHALL hold the isize encodings, MMIO offsets (counter 0, gpio 4), and FSM state typedef.
REQ-025 RAM storage SHALL be sub-module dmem_byte_ram: MP_DEPTH words, 4 byte-write enables, combinational read.

Verification
REQ-026 Store word 32'h8899_AABB at 0x10, load byte signed at 0x11 -> ordata=32'hFFFF_FFAA, ofault=0.
REQ-027 Store half 16'h1234 at 0x12, load word 0x10 -> 32'h1234_AABB; load half unsigned 0x12 -> 32'h0000_1234.
REQ-028 MP_RD_LATENCY=3: load accepted at cycle 0 -> obusy high cycles 1-2, ovalid cycle 3; ireq at cycle 1 dropped.
REQ-029 Load half at 0x03 -> ovalid, ofault=1, ordata=0; load word 0x400 (depth 256) -> fault; RAM unchanged.
REQ-030 Word store 32'hDEAD_BEEF to base+4 -> ogpio=32'hDEAD_BEEF next cycle; byte store to base+4 -> fault, ogpio unchanged.
REQ-031 Read counter twice 5 cycles apart -> difference 5; irst mid-WAIT -> no ovalid, counter reads restart near 0.
